rsa_uart_ctrl: RTL and testbench

Command sequencer between the UART byte receiver/transmitter and an iterative modular-exponentiation engine in the RSA-over-UART design. It parses a two-byte command (opcode, operand) from the RX side and selects encrypt or decrypt key material. It starts the engine, bounds its run time with a watchdog, and returns exactly one response byte per command through the TX side. Error bytes replace the result for bad opcodes, out-of-range operands and engine timeouts.

---
 rtl/rsa_uart_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rsa_uart_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_uart_ctrl.sv
// rsa_uart_ctrl: two-byte command sequencer between the UART RX/TX byte
// interfaces and an iterative modular-exponentiation engine.
// Every accepted command produces exactly one response byte on TX.
// That byte is either the engine result or an error code:
// '?' for a bad opcode, '!' for an out-of-range operand, 'X' for an engine timeout.
module rsa_uart_ctrl #(
  parameter int unsigned N_MOD   = 143,
  parameter int unsigned E_KEY   = 7,
  parameter int unsigned D_KEY   = 103,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_send,
  input  logic       i_tx_busy,
  output logic       o_exp_start,
  output logic [7:0] o_exp_base,
  output logic [7:0] o_exp_exp,
  output logic [7:0] o_exp_mod,
  input  logic       i_exp_done,
  input  logic [7:0] i_exp_result,
  output logic       o_busy,
  output logic       o_overrun,
  output logic [7:0] o_err_count
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);

  localparam logic [7:0]      C_OP_ENC  = 8'h45;
  localparam logic [7:0]      C_OP_DEC  = 8'h44;
  localparam logic [7:0]      C_ERR_OP  = 8'h3F;
  localparam logic [7:0]      C_ERR_RNG = 8'h21;
  localparam logic [7:0]      C_ERR_TMO = 8'h58;
  localparam logic [7:0]      C_MOD     = 8'(N_MOD);
  localparam logic [7:0]      C_E_KEY   = 8'(E_KEY);
  localparam logic [7:0]      C_D_KEY   = 8'(D_KEY);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPERAND = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SEND    = 3'd4,
    S_TXWAIT  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [7:0]      r_tx_data;
  logic            r_exp_start;
  logic [7:0]      r_exp_base;
  logic [7:0]      r_exp_exp;
  logic            r_busy;
  logic            r_overrun;
  logic [7:0]      r_err_count;
  logic [WD_W-1:0] r_wd;
  logic            r_mode_enc;
  logic            r_tx_guard;

  logic [7:0]      w_tx_data_nxt;
  logic [7:0]      w_exp_base_nxt;
  logic [7:0]      w_exp_exp_nxt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            w_mode_enc_nxt;
  logic            w_tx_guard_nxt;
  logic            w_err_inc;
  logic            w_tx_send;
  logic            w_rx_drop;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, next datapath values and the TX request strobe
  always_comb begin
    w_next         = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_exp_base_nxt = r_exp_base;
    w_exp_exp_nxt  = r_exp_exp;
    w_wd_nxt       = r_wd;
    w_mode_enc_nxt = r_mode_enc;
    w_tx_guard_nxt = r_tx_guard;
    w_err_inc      = 1'b0;
    w_tx_send      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == C_OP_ENC) begin
            w_mode_enc_nxt = 1'b1;
            w_next         = S_OPERAND;
          end else if (i_rx_data == C_OP_DEC) begin
            w_mode_enc_nxt = 1'b0;
            w_next         = S_OPERAND;
          end else begin
            w_tx_data_nxt = C_ERR_OP;
            w_err_inc     = 1'b1;
            w_next        = S_SEND;
          end
        end
      end

      S_OPERAND: begin
        if (i_rx_valid) begin
          if (i_rx_data >= C_MOD) begin
            w_tx_data_nxt = C_ERR_RNG;
            w_err_inc     = 1'b1;
            w_next        = S_SEND;
          end else begin
            w_exp_base_nxt = i_rx_data;
            w_exp_exp_nxt  = r_mode_enc ? C_E_KEY : C_D_KEY;
            w_next         = S_START;
          end
        end
      end

      S_START: begin
        w_wd_nxt = '0;
        w_next   = S_WAIT;
      end

      S_WAIT: begin
        w_wd_nxt = r_wd + WD_W'(1);
        // A completion in the timeout cycle still returns the real result
        if (i_exp_done) begin
          w_tx_data_nxt = i_exp_result;
          w_next        = S_SEND;
        end else if (r_wd == C_WD_LAST) begin
          w_tx_data_nxt = C_ERR_TMO;
          w_err_inc     = 1'b1;
          w_next        = S_SEND;
        end
      end

      S_SEND: begin
        if (!i_tx_busy) begin
          w_tx_send      = 1'b1;
          w_tx_guard_nxt = 1'b1;
          w_next         = S_TXWAIT;
        end
      end

      S_TXWAIT: begin
        // tx_busy only rises the cycle after tx_send, so skip one cycle first
        if (r_tx_guard) begin
          w_tx_guard_nxt = 1'b0;
        end else if (!i_tx_busy) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Bytes arriving while a command is in flight are dropped
  always_comb begin
    w_rx_drop = 1'b0;
    if (i_rx_valid) begin
      case (r_state)
        S_START, S_WAIT, S_SEND, S_TXWAIT: w_rx_drop = 1'b1;
        default:                           w_rx_drop = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_data   <= 8'h00;
      r_exp_start <= 1'b0;
      r_exp_base  <= 8'h00;
      r_exp_exp   <= 8'h00;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_count <= 8'h00;
      r_wd        <= '0;
      r_mode_enc  <= 1'b0;
      r_tx_guard  <= 1'b0;
    end else begin
      r_tx_data   <= w_tx_data_nxt;
      r_exp_start <= (w_next == S_START);
      r_exp_base  <= w_exp_base_nxt;
      r_exp_exp   <= w_exp_exp_nxt;
      r_busy      <= (w_next != S_IDLE);
      r_wd        <= w_wd_nxt;
      r_mode_enc  <= w_mode_enc_nxt;
      r_tx_guard  <= w_tx_guard_nxt;
      if (w_rx_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_err_inc && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_send   = w_tx_send;
  assign o_exp_start = r_exp_start;
  assign o_exp_base  = r_exp_base;
  assign o_exp_exp   = r_exp_exp;
  assign o_exp_mod   = C_MOD;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_rsa_uart_ctrl.sv
// Directed bench for rsa_uart_ctrl.
// It drives the controller against a behavioural 20-cycle modexp engine and
// a UART transmitter that stays busy for 10 cycles.
module tb_rsa_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       exp_start;
  logic [7:0] exp_base;
  logic [7:0] exp_exp;
  logic [7:0] exp_mod;
  logic       exp_done;
  logic [7:0] exp_result;
  logic       busy;
  logic       overrun;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  rsa_uart_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_send    (tx_send),
    .i_tx_busy    (tx_busy),
    .o_exp_start  (exp_start),
    .o_exp_base   (exp_base),
    .o_exp_exp    (exp_exp),
    .o_exp_mod    (exp_mod),
    .i_exp_done   (exp_done),
    .i_exp_result (exp_result),
    .o_busy       (busy),
    .o_overrun    (overrun),
    .o_err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Square-and-multiply reference for the engine model
  function automatic logic [7:0] modexp(input logic [7:0] b, input logic [7:0] e,
                                        input logic [7:0] m);
    logic [15:0] r;
    logic [15:0] x;
    logic [15:0] m16;
    m16 = 16'(m);
    r   = 16'd1;
    x   = 16'(b) % m16;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * x) % m16;
      x = (x * x) % m16;
    end
    return 8'(r);
  endfunction

  // Engine model: done 20 cycles after start unless disabled
  logic       eng_en;
  int         eng_cnt;
  logic [7:0] eng_b;
  logic [7:0] eng_e;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt    <= 0;
      exp_done   <= 1'b0;
      exp_result <= 8'h00;
      eng_b      <= 8'h00;
      eng_e      <= 8'h00;
    end else begin
      exp_done <= 1'b0;
      if (exp_start) begin
        eng_cnt <= 20;
        eng_b   <= exp_base;
        eng_e   <= exp_exp;
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1 && eng_en) begin
          exp_done   <= 1'b1;
          exp_result <= modexp(eng_b, eng_e, exp_mod);
        end
      end
    end
  end

  // Transmitter model: busy from the cycle after tx_send for 10 cycles
  int tx_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (tx_send) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 10;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_cnt  <= 0;
      tx_busy <= 1'b0;
    end
  end

  // Event monitor
  int         cyc     = 0;
  int         n_send  = 0;
  int         n_start = 0;
  int         t_send  = 0;
  int         t_start = 0;
  int         t_done  = 0;
  logic [7:0] tx_seen = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_send) begin
      n_send  <= n_send + 1;
      t_send  <= cyc;
      tx_seen <= tx_data;
    end
    if (exp_start) begin
      n_start <= n_start + 1;
      t_start <= cyc;
    end
    if (exp_done) t_done <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_send(input int base, input int max, input string tag);
    int k;
    k = 0;
    while (n_send == base && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_send != base), 32'd1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k;
    k = 0;
    while (busy && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  int ns;
  int nst;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    eng_en   = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_exp_start", 32'(exp_start), 32'd0);
    chk("rst_exp_base", 32'(exp_base), 32'h00);
    chk("rst_exp_exp", 32'(exp_exp), 32'h00);
    chk("rst_exp_mod", 32'(exp_mod), 32'd143);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Encrypt 2: 2^7 mod 143 = 128
    ns = n_send; nst = n_start;
    send_byte(8'h45);
    chk("enc_op_busy", 32'(busy), 32'd1);
    send_byte(8'h02);
    chk("enc_start", 32'(exp_start), 32'd1);
    chk("enc_exp", 32'(exp_exp), 32'd7);
    chk("enc_base", 32'(exp_base), 32'd2);
    @(negedge clk);
    chk("enc_start_once", 32'(exp_start), 32'd0);
    wait_send(ns, 200, "enc_send_seen");
    chk("enc_result", 32'(tx_seen), 32'h80);
    chk("enc_done_to_send", 32'(t_send - t_done), 32'd1);
    wait_idle(200, "enc_idle");
    chk("enc_one_send", 32'(n_send - ns), 32'd1);
    chk("enc_one_start", 32'(n_start - nst), 32'd1);
    chk("enc_err", 32'(err_count), 32'd0);

    // Decrypt 128 back to 2
    ns = n_send;
    send_byte(8'h44);
    send_byte(8'h80);
    chk("dec_exp", 32'(exp_exp), 32'd103);
    chk("dec_base", 32'(exp_base), 32'h80);
    wait_send(ns, 200, "dec_send_seen");
    chk("dec_result", 32'(tx_seen), 32'h02);
    chk("dec_done_to_send", 32'(t_send - t_done), 32'd1);
    wait_idle(200, "dec_idle");

    // Bad opcode answers '?' on the very next cycle
    ns = n_send;
    send_byte(8'h5A);
    chk("badop_send", 32'(tx_send), 32'd1);
    chk("badop_data", 32'(tx_data), 32'h3F);
    chk("badop_err", 32'(err_count), 32'd1);
    wait_send(ns, 50, "badop_send_seen");
    wait_idle(200, "badop_idle");
    ns = n_send;
    send_byte(8'h45);
    send_byte(8'h02);
    wait_send(ns, 200, "after_badop_seen");
    chk("after_badop_result", 32'(tx_seen), 32'h80);
    wait_idle(200, "after_badop_idle");

    // Operand 0x8F equals the modulus: rejected with '!'
    ns = n_send; nst = n_start;
    send_byte(8'h45);
    send_byte(8'h8F);
    chk("rng_no_start", 32'(exp_start), 32'd0);
    chk("rng_send", 32'(tx_send), 32'd1);
    chk("rng_data", 32'(tx_data), 32'h21);
    wait_send(ns, 50, "rng_send_seen");
    wait_idle(200, "rng_idle");
    chk("rng_start_count", 32'(n_start - nst), 32'd0);
    chk("rng_err", 32'(err_count), 32'd2);

    // Engine never finishes: 'X' at START+TIMEOUT+1
    eng_en = 1'b0;
    ns = n_send;
    send_byte(8'h44);
    send_byte(8'h10);
    wait_send(ns, 5000, "tmo_send_seen");
    chk("tmo_data", 32'(tx_seen), 32'h58);
    chk("tmo_latency", 32'(t_send - t_start), 32'd4097);
    chk("tmo_err", 32'(err_count), 32'd3);
    wait_idle(200, "tmo_idle");
    eng_en = 1'b1;

    // Byte injected during WAIT: dropped, sets overrun, result still sent
    ns = n_send;
    send_byte(8'h45);
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    chk("ovr_pre", 32'(overrun), 32'd0);
    send_byte(8'h55);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_send(ns, 200, "ovr_send_seen");
    chk("ovr_result", 32'(tx_seen), 32'h2A);
    wait_idle(200, "ovr_idle");
    repeat (5) @(negedge clk);
    chk("ovr_one_send", 32'(n_send - ns), 32'd1);
    chk("ovr_err", 32'(err_count), 32'd3);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of WAIT
    send_byte(8'h44);
    send_byte(8'h05);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_send", 32'(tx_send), 32'd0);
    chk("mid_rst_start", 32'(exp_start), 32'd0);
    chk("mid_rst_base", 32'(exp_base), 32'h00);
    chk("mid_rst_exp", 32'(exp_exp), 32'h00);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ns = n_send;
    repeat (40) @(negedge clk);
    chk("post_rst_no_send", 32'(n_send - ns), 32'd0);
    ns = n_send;
    send_byte(8'h45);
    send_byte(8'h04);
    wait_send(ns, 200, "post_rst_seen");
    chk("post_rst_result", 32'(tx_seen), 32'h52);
    wait_idle(200, "post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
